dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_if.sv | 26 ++
 rtl/dmem_ctrl.sv | 98 +++++++++
 tb/tb_dmem_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// CPU-side data-memory port: request fields driven by the core, response fields by the controller.
// Handshake: a request is taken on a rising edge where (r_v | w_v) is high and busy is low;
// dmem_resp_v is a one-cycle pulse, and dmem_resp / adr_err are meaningful only while it is high.
interface dmem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            r_v;
  logic            w_v;
  logic [XLEN-1:0] data_adr;
  logic [XLEN-1:0] data_o;
  logic [3:0]      strobe;
  logic [XLEN-1:0] dmem_resp;
  logic            dmem_resp_v;
  logic            busy;
  logic            adr_err;

  modport master (
    output r_v, w_v, data_adr, data_o, strobe,
    input  dmem_resp, dmem_resp_v, busy, adr_err
  );

  modport slave (
    input  r_v, w_v, data_adr, data_o, strobe,
    output dmem_resp, dmem_resp_v, busy, adr_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-addressed on-chip data RAM behind the core's dmem port, with a fixed number of wait
// states, single-cycle response pulse, and error flagging for misaligned/out-of-range accesses.
module dmem_ctrl #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus,
  output logic [1:0]  state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [3:0]      wait_cnt;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      strb_q;
  logic            wr_q;
  logic            err_q;
  logic [XLEN-1:0] resp_q;
  logic [XLEN-1:0] rd_word;
  logic            accept;
  logic            req_err;

  logic [XLEN-1:0] mem [DEPTH];

  assign accept  = (state == S_IDLE) && (bus.r_v || bus.w_v);
  // Upper address bits beyond the RAM are an error rather than an alias.
  assign req_err = (bus.data_adr[1:0] != 2'b00) ||
                   ((bus.data_adr >> (AW + 2)) != '0) ||
                   (bus.r_v && bus.w_v);
  assign rd_word = (wr_q || err_q) ? '0 : mem[idx_q];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (wait_cnt == WS_LAST) next_state = S_RESP;
      S_RESP: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.dmem_resp_v = (state == S_RESP);
    bus.busy        = (state != S_IDLE);
    bus.adr_err     = (state == S_RESP) && err_q;
    bus.dmem_resp   = (state == S_RESP) ? rd_word : resp_q;
    state_dbg       = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      resp_q   <= '0;
    end else begin
      if (accept) begin
        idx_q   <= bus.data_adr[AW+1:2];
        wdata_q <= bus.data_o;
        strb_q  <= bus.strobe;
        wr_q    <= bus.w_v;
        err_q   <= req_err;
      end
      if (state == S_WAIT) wait_cnt <= (wait_cnt == WS_LAST) ? 4'd0 : wait_cnt + 4'd1;
      // Capture the presented word so dmem_resp keeps it after the pulse ends.
      if (state == S_RESP) resp_q <= rd_word;
    end
  end

  // Writes land at the end of RESP; a reset in that cycle drops them.
  always_ff @(posedge clk) begin
    if (!rst && state == S_RESP && wr_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one instance with one wait state, one with none.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;
  logic [1:0] state_dbg0;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.XLEN(32)) bus ();
  dmem_ctrl_if #(.XLEN(32)) bus0 ();

  dmem_ctrl #(.XLEN(32), .DEPTH(64), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );
  dmem_ctrl #(.XLEN(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(state_dbg0)
  );

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp0_q[$];
  logic [31:0] model [64];
  logic [32:0] mon_e;
  logic [32:0] mon0_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitors: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.dmem_resp_v === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: got resp 0x%0h err %0b expected no pulse", bus.dmem_resp, bus.adr_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp", {31'd0, bus.dmem_resp, bus.adr_err}, {31'd0, mon_e});
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.dmem_resp_v === 1'b1) begin
      if (exp0_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp0: got resp 0x%0h err %0b expected no pulse", bus0.dmem_resp, bus0.adr_err);
      end else begin
        mon0_e = exp0_q.pop_front();
        check("resp0", {31'd0, bus0.dmem_resp, bus0.adr_err}, {31'd0, mon0_e});
      end
    end
  end

  task automatic req(input bit sel, input logic r, input logic w, input logic [31:0] adr,
                     input logic [31:0] data, input logic [3:0] strb,
                     input logic [31:0] er, input logic ee);
    int k;
    logic v;
    @(negedge clk);
    if (sel) begin
      bus0.r_v = r; bus0.w_v = w; bus0.data_adr = adr; bus0.data_o = data; bus0.strobe = strb;
      exp0_q.push_back({er, ee});
    end else begin
      bus.r_v = r; bus.w_v = w; bus.data_adr = adr; bus.data_o = data; bus.strobe = strb;
      exp_q.push_back({er, ee});
    end
    @(posedge clk);
    @(negedge clk);
    bus.r_v = 1'b0; bus.w_v = 1'b0; bus0.r_v = 1'b0; bus0.w_v = 1'b0;
    k = 1;
    v = sel ? bus0.dmem_resp_v : bus.dmem_resp_v;
    while (v !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
      v = sel ? bus0.dmem_resp_v : bus.dmem_resp_v;
    end
    check(sel ? "latency0" : "latency", 64'(k), sel ? 64'd1 : 64'd2);
  endtask

  task automatic write_word(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] strb);
    req(1'b0, 1'b0, 1'b1, adr, data, strb, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) if (strb[i]) model[adr[7:2]][8*i +: 8] = data[8*i +: 8];
  endtask

  task automatic read_word(input logic [31:0] adr);
    req(1'b0, 1'b1, 1'b0, adr, 32'd0, 4'd0, model[adr[7:2]], 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.r_v = 0; bus.w_v = 0; bus.data_adr = 0; bus.data_o = 0; bus.strobe = 0;
    bus0.r_v = 0; bus0.w_v = 0; bus0.data_adr = 0; bus0.data_o = 0; bus0.strobe = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp", 64'(bus.dmem_resp), 64'd0);
    check("rst_resp_v", 64'(bus.dmem_resp_v), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_adr_err", 64'(bus.adr_err), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_busy0", 64'(bus0.busy), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) write_word(32'(i * 4), 32'h5A000000 | 32'(i * 32'h00010101), 4'hF);

    // Full write then read back.
    write_word(32'h10, 32'hDEADBEEF, 4'hF);
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0, 32'hDEADBEEF, 1'b0);

    // Byte-lane merge.
    write_word(32'h20, 32'h11223344, 4'hF);
    write_word(32'h20, 32'hAABBCCDD, 4'b0101);
    req(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0, 32'h11BB33DD, 1'b0);

    // Error cases: none may touch RAM.
    req(1'b0, 1'b1, 1'b0, 32'h22, 32'd0, 4'd0, 32'd0, 1'b1);
    req(1'b0, 1'b0, 1'b1, 32'd256, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1);
    req(1'b0, 1'b0, 1'b1, 32'h21, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1);
    req(1'b0, 1'b1, 1'b0, 32'h1000, 32'd0, 4'd0, 32'd0, 1'b1);
    req(1'b0, 1'b1, 1'b1, 32'h30, 32'h12345678, 4'hF, 32'd0, 1'b1);
    req(1'b0, 1'b1, 1'b0, 32'h30, 32'd0, 4'd0, 32'h5A0C0C0C, 1'b0);
    req(1'b0, 1'b0, 1'b1, 32'h18, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
    for (int i = 0; i < 64; i++) read_word(32'(i * 4));

    // A request raised while busy must be dropped.
    @(negedge clk);
    bus.r_v = 1'b1; bus.data_adr = 32'h10;
    exp_q.push_back({32'hDEADBEEF, 1'b0});
    @(posedge clk);
    @(negedge clk);
    check("busy_wait", 64'(bus.busy), 64'd1);
    bus.r_v = 1'b0; bus.w_v = 1'b1; bus.data_adr = 32'h14; bus.data_o = 32'd0; bus.strobe = 4'hF;
    @(negedge clk);
    bus.w_v = 1'b0;
    repeat (4) @(negedge clk);
    read_word(32'h14);

    // Zero wait states, request held high.
    req(1'b1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
    @(negedge clk);
    bus0.r_v = 1'b1; bus0.data_adr = 32'h10;
    repeat (3) exp0_q.push_back({32'hCAFEF00D, 1'b0});
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_pattern", 64'(bus0.dmem_resp_v), (c % 2 == 0) ? 64'd1 : 64'd0);
    end
    bus0.r_v = 1'b0;

    // Reset while a write waits: nothing commits, no pulse.
    write_word(32'h40, 32'd0, 4'hF);
    @(negedge clk);
    bus.w_v = 1'b1; bus.data_adr = 32'h40; bus.data_o = 32'h12345678; bus.strobe = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.w_v = 1'b0;
    check("abort_in_wait", 64'(state_dbg), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_resp_v", 64'(bus.dmem_resp_v), 64'd0);
    check("abort_state", 64'(state_dbg), 64'd0);
    repeat (3) @(negedge clk);
    read_word(32'h40);

    repeat (4) @(negedge clk);
    check("pending_exp", 64'(exp_q.size()), 64'd0);
    check("pending_exp0", 64'(exp0_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
